// File: rtl/snow64_bfloat16_add.sv
// Multi-cycle bfloat16 adder (IDLE -> ALIGN -> ADD -> NORM), one operation in flight.
// Define SNOW64_BFLOAT16_ADD_RNE_EN for round-to-nearest-even; default build truncates.
module snow64_bfloat16_add (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_start,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_data_valid,
  output logic [15:0] out_data,
  output logic        out_can_accept_cmd
);

  typedef enum logic [1:0] {ST_IDLE, ST_ALIGN, ST_ADD, ST_NORM} state_e;

  localparam logic [15:0] QNAN = 16'h7FC0;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic        sign_q, sign_d;
  logic        eff_sub_q, eff_sub_d;
  logic [7:0]  exp_q, exp_d;
  logic [10:0] x_sig_q, x_sig_d;
  logic [10:0] y_sig_q, y_sig_d;
  logic        special_q, special_d;
  logic [15:0] special_val_q, special_val_d;
  logic [11:0] sum_q, sum_d;
  logic        valid_q, valid_d;
  logic [15:0] data_q, data_d;

  // ---------------- state register ----------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      a_q           <= '0;
      b_q           <= '0;
      sign_q        <= 1'b0;
      eff_sub_q     <= 1'b0;
      exp_q         <= '0;
      x_sig_q       <= '0;
      y_sig_q       <= '0;
      special_q     <= 1'b0;
      special_val_q <= '0;
      sum_q         <= '0;
      valid_q       <= 1'b0;
      data_q        <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      sign_q        <= sign_d;
      eff_sub_q     <= eff_sub_d;
      exp_q         <= exp_d;
      x_sig_q       <= x_sig_d;
      y_sig_q       <= y_sig_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
      sum_q         <= sum_d;
      valid_q       <= valid_d;
      data_q        <= data_d;
    end
  end

  // ---------------- next state ----------------
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_start) state_d = ST_ALIGN;
      ST_ALIGN: state_d = ST_ADD;
      ST_ADD:   state_d = ST_NORM;
      ST_NORM:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------- ALIGN datapath ----------------
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [14:0] a_mag, b_mag;
  logic [15:0] x_op, y_op;
  logic [7:0]  x_sig8, y_sig8, exp_diff;
  logic [10:0] y_full, y_shift, lost_mask;
  logic [15:0] spec_val;
  logic        spec_hit;

  always_comb begin
    a_nan = (a_q[14:7] == 8'hFF) && (a_q[6:0] != 7'd0);
    b_nan = (b_q[14:7] == 8'hFF) && (b_q[6:0] != 7'd0);
    a_inf = (a_q[14:7] == 8'hFF) && (a_q[6:0] == 7'd0);
    b_inf = (b_q[14:7] == 8'hFF) && (b_q[6:0] == 7'd0);
    // Denormals flush to zero by zeroing the whole magnitude.
    a_mag = (a_q[14:7] == 8'd0) ? 15'd0 : a_q[14:0];
    b_mag = (b_q[14:7] == 8'd0) ? 15'd0 : b_q[14:0];
    if (a_mag >= b_mag) begin
      x_op = {a_q[15], a_mag};
      y_op = {b_q[15], b_mag};
    end else begin
      x_op = {b_q[15], b_mag};
      y_op = {a_q[15], a_mag};
    end
    x_sig8    = {x_op[14:7] != 8'd0, x_op[6:0]};
    y_sig8    = {y_op[14:7] != 8'd0, y_op[6:0]};
    exp_diff  = x_op[14:7] - y_op[14:7];
    y_full    = {y_sig8, 3'b000};
    lost_mask = '0;
    if (exp_diff >= 8'd11) begin
      y_shift = {10'd0, y_sig8 != 8'd0};
    end else begin
      lost_mask = (11'd1 << exp_diff) - 11'd1;
      y_shift   = y_full >> exp_diff;
      y_shift[0] = y_shift[0] | (|(y_full & lost_mask));
    end

    spec_hit = 1'b1;
    spec_val = QNAN;
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[15] != b_q[15]))) spec_val = QNAN;
    else if (a_inf)                                                  spec_val = a_q;
    else if (b_inf)                                                  spec_val = b_q;
    else                                                             spec_hit = 1'b0;
  end

  always_comb begin
    a_d           = a_q;
    b_d           = b_q;
    sign_d        = sign_q;
    eff_sub_d     = eff_sub_q;
    exp_d         = exp_q;
    x_sig_d       = x_sig_q;
    y_sig_d       = y_sig_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    sum_d         = sum_q;
    if (state_q == ST_IDLE && in_start) begin
      a_d = in_a;
      b_d = in_b;
    end
    if (state_q == ST_ALIGN) begin
      sign_d        = x_op[15];
      eff_sub_d     = x_op[15] ^ y_op[15];
      exp_d         = x_op[14:7];
      x_sig_d       = {x_sig8, 3'b000};
      y_sig_d       = y_shift;
      special_d     = spec_hit;
      special_val_d = spec_val;
    end
    if (state_q == ST_ADD) begin
      // X has the larger magnitude, so the difference never goes negative.
      sum_d = eff_sub_q ? ({1'b0, x_sig_q} - {1'b0, y_sig_q})
                        : ({1'b0, x_sig_q} + {1'b0, y_sig_q});
    end
  end

  // ---------------- NORM datapath ----------------
  logic [3:0]        lz;
  logic [10:0]       norm_m;
  logic signed [9:0] e_norm, e_fin;
  logic              rnd_inc;
  logic [8:0]        mant_r;
  logic [15:0]       result;
`ifndef SNOW64_BFLOAT16_ADD_RNE_EN
  logic              grs_unused;
`endif

  always_comb begin
    lz = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (sum_q[i]) lz = 4'(10 - i);
    end
    if (sum_q[11]) begin
      norm_m = {sum_q[11:2], sum_q[1] | sum_q[0]};
      e_norm = $signed({2'b00, exp_q}) + 10'sd1;
    end else begin
      norm_m = sum_q[10:0] << lz;
      e_norm = $signed({2'b00, exp_q}) - $signed({6'd0, lz});
    end
`ifdef SNOW64_BFLOAT16_ADD_RNE_EN
    rnd_inc = norm_m[2] & (norm_m[1] | norm_m[0] | norm_m[3]);
`else
    rnd_inc    = 1'b0;
    grs_unused = |norm_m[2:0];
`endif
    mant_r = {1'b0, norm_m[10:3]} + {8'd0, rnd_inc};
    e_fin  = mant_r[8] ? (e_norm + 10'sd1) : e_norm;

    if (special_q)                result = special_val_q;
    else if (sum_q == 12'd0)      result = 16'h0000;
    else if (e_norm <= 10'sd0)    result = {sign_q, 15'd0};
    else if (e_fin >= 10'sd255)   result = {sign_q, 8'hFF, 7'd0};
    else                          result = {sign_q, e_fin[7:0], mant_r[8] ? 7'd0 : mant_r[6:0]};
  end

  always_comb begin
    valid_d = (state_q == ST_NORM);
    data_d  = (state_q == ST_NORM) ? result : data_q;
  end

  // ---------------- outputs ----------------
  always_comb begin
    out_can_accept_cmd = (state_q == ST_IDLE);
    out_data_valid     = valid_q;
    out_data           = data_q;
  end

endmodule

// File: tb/tb_snow64_bfloat16_add.sv
// Self-checking bench for snow64_bfloat16_add: real-valued reference model plus
// hand-computed vectors; build with SNOW64_BFLOAT16_ADD_RNE_EN to check the RNE variant.
module tb_snow64_bfloat16_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_start = 1'b0;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        out_data_valid;
  logic [15:0] out_data;
  logic        out_can_accept_cmd;

  snow64_bfloat16_add dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_start           (in_start),
    .in_a               (in_a),
    .in_b               (in_b),
    .out_data_valid     (out_data_valid),
    .out_data           (out_data),
    .out_can_accept_cmd (out_can_accept_cmd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] res;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real decode(input logic [15:0] v);
    real m;
    int  e;
    if (v[14:7] == 8'd0) return 0.0;
    m = real'(128 + int'(v[6:0])) / 128.0;
    e = int'(v[14:7]) - 127;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] encode(input real v);
    logic s;
    real  mag, rem;
    int   e, biased, mant;
    if (v == 0.0) return 16'h0000;
    s   = (v < 0.0);
    mag = s ? -v : v;
    e   = 0;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0)  begin mag = mag * 2.0; e--; end
    biased = e + 127;
    if (biased <= 0) return {s, 15'd0};
    mant = $rtoi(mag * 128.0);
    rem  = mag * 128.0 - real'(mant);
`ifdef SNOW64_BFLOAT16_ADD_RNE_EN
    if (rem > 0.5 || (rem == 0.5 && (mant % 2) == 1)) mant++;
`endif
    if (mant == 256) begin mant = 128; biased++; end
    if (biased >= 255) return {s, 8'hFF, 7'd0};
    return {s, 8'(biased), 7'(mant - 128)};
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b);
    logic a_nan, b_nan, a_inf, b_inf;
    a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 0);
    b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 0);
    a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 0);
    b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[15] != b[15])) return 16'h7FC0;
    if (a_inf) return a;
    if (b_inf) return b;
    return encode(decode(a) + decode(b));
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() != 0 && cyc >= exp_q[0].due) begin
        check("valid_at_latency", 32'(out_data_valid), 32'd1);
        if (out_data_valid) check("result", 32'(out_data), 32'(exp_q[0].res));
        void'(exp_q.pop_front());
      end else if (out_data_valid) begin
        check("spurious_valid", 32'(out_data_valid), 32'd0);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    int waited = 0;
    @(negedge clk);
    while (!out_can_accept_cmd && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(out_can_accept_cmd), 32'd1);
    in_a = a;
    in_b = b;
    in_start = 1'b1;
    exp_q.push_back('{res: model_add(a, b), due: cyc + 4});
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  // a, b, expected (truncate), expected (RNE)
  typedef struct {
    logic [15:0] a, b, trunc, rne;
  } vec_t;
  vec_t vecs[$] = '{
    '{16'h3F80, 16'h3F80, 16'h4000, 16'h4000},
    '{16'h3FC0, 16'hBFC0, 16'h0000, 16'h0000},
    '{16'h4040, 16'h3F00, 16'h4060, 16'h4060},
    '{16'h4000, 16'hBF80, 16'h3F80, 16'h3F80},
    '{16'h7F7F, 16'h7F7F, 16'h7F80, 16'h7F80},
    '{16'h7F80, 16'hFF80, 16'h7FC0, 16'h7FC0},
    '{16'h7FC0, 16'h3F80, 16'h7FC0, 16'h7FC0},
    '{16'hFF80, 16'h4000, 16'hFF80, 16'hFF80},
    '{16'h0001, 16'h3F80, 16'h3F80, 16'h3F80},
    '{16'h3F80, 16'h3B00, 16'h3F80, 16'h3F80},
    '{16'h3F80, 16'h3BC0, 16'h3F80, 16'h3F81},
    '{16'h3F81, 16'h3B80, 16'h3F81, 16'h3F82},
    '{16'h3F80, 16'hB780, 16'h3F7F, 16'h3F80},
    '{16'hC0A0, 16'h4000, 16'hC040, 16'hC040},
    '{16'h0000, 16'h8000, 16'h0000, 16'h0000},
    '{16'h8000, 16'h8000, 16'h0000, 16'h0000},
    '{16'h0100, 16'h8080, 16'h0080, 16'h0080},
    '{16'h80C0, 16'h0080, 16'h8000, 16'h8000}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_bad);
    $fatal(1);
  end

  initial begin
    logic [15:0] lit;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_data_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'h0000);
    check("rst_accept", 32'(out_can_accept_cmd), 32'd1);
    rst_n = 1'b1;

    // First transaction: busy flag and exact latency
    @(negedge clk);
    in_a = 16'h3F80; in_b = 16'h3F80; in_start = 1'b1;
    exp_q.push_back('{res: 16'h4000, due: cyc + 4});
    @(negedge clk);
    in_start = 1'b0;
    check("busy_align", 32'(out_can_accept_cmd), 32'd0);
    @(negedge clk);
    check("busy_add", 32'(out_can_accept_cmd), 32'd0);
    @(negedge clk);
    check("busy_norm", 32'(out_can_accept_cmd), 32'd0);
    check("no_early_valid", 32'(out_data_valid), 32'd0);
    @(negedge clk);
    check("idle_after_done", 32'(out_can_accept_cmd), 32'd1);
    @(negedge clk);
    check("valid_one_cycle", 32'(out_data_valid), 32'd0);
    check("data_held", 32'(out_data), 32'h4000);

    // Model pinned by hand-computed literals, DUT checked against the model
    foreach (vecs[i]) begin
`ifdef SNOW64_BFLOAT16_ADD_RNE_EN
      lit = vecs[i].rne;
`else
      lit = vecs[i].trunc;
`endif
      check($sformatf("model_vec%0d", i), 32'(model_add(vecs[i].a, vecs[i].b)), 32'(lit));
      issue(vecs[i].a, vecs[i].b);
    end
    drain();

    // start held through busy cycles, then re-asserted in the valid cycle
    @(negedge clk);
    in_a = 16'h4000; in_b = 16'h4000; in_start = 1'b1;
    exp_q.push_back('{res: 16'h4080, due: cyc + 4});
    @(negedge clk);
    check("held_busy_align", 32'(out_can_accept_cmd), 32'd0);
    @(negedge clk);
    check("held_busy_add", 32'(out_can_accept_cmd), 32'd0);
    @(negedge clk);
    check("held_busy_norm", 32'(out_can_accept_cmd), 32'd0);
    @(negedge clk);
    check("valid_with_start", 32'(out_data_valid), 32'd1);
    in_a = 16'h3F80; in_b = 16'h3F00;
    exp_q.push_back('{res: model_add(16'h3F80, 16'h3F00), due: cyc + 4});
    check("model_1p5", 32'(model_add(16'h3F80, 16'h3F00)), 32'h3FC0);
    @(negedge clk);
    in_start = 1'b0;
    check("valid_drops", 32'(out_data_valid), 32'd0);
    check("back_to_back_busy", 32'(out_can_accept_cmd), 32'd0);
    drain();
    repeat (6) @(negedge clk);

    // Reset during ADD abandons the operation
    issue(16'h3F80, 16'h4000);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_valid", 32'(out_data_valid), 32'd0);
    check("midrst_data", 32'(out_data), 32'h0000);
    check("midrst_accept", 32'(out_can_accept_cmd), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_pulse_data", 32'(out_data), 32'h0000);
    issue(16'h3F80, 16'h4000);
    check("model_3p0", 32'(model_add(16'h3F80, 16'h4000)), 32'h4040);
    drain();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
